// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_pkg                                                                    |
// | Shared sizing constants and sequencer state type for the 512-point FFT.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fft_pkg;

    localparam int FFT_N       = 512;
    localparam int FFT_LEVEL   = 9;
    // AGU needs LEVEL*N/2 + 1 cycles; the margin absorbs pipeline slack.
    localparam int FFT_TIMEOUT = FFT_LEVEL * FFT_N / 2 + 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ARM     = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_UNLOAD  = 3'd4
    } fft_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/bitrev.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bitrev                                                                     |
// | Pure wiring: reverses the bit order of a LEVEL-bit index.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bitrev
    import fft_pkg::*;
#(
    parameter int LEVEL = FFT_LEVEL
) (
    input  logic [LEVEL-1:0] i_data,
    output logic [LEVEL-1:0] o_data
);

    generate
        for (genvar g = 0; g < LEVEL; g++) begin : g_bit
            assign o_data[g] = i_data[LEVEL-1-g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fft_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_ctrl                                                                   |
// | Frame sequencer: LOAD samples, ARM/run the AGU, UNLOAD results.            |
// | FFT_CTRL_BITREV_EN: bit-reversed load addressing (natural-order input).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int N       = FFT_N,
    parameter int LEVEL   = FFT_LEVEL,
    parameter int TIMEOUT = FFT_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [LEVEL-1:0] load_addr,
    output logic             load_we,
    output logic             fft_load,
    output logic             agu_reset,
    output logic             fft_enable,
    input  logic             fft_done,
    output logic [LEVEL-1:0] unload_addr,
    output logic             out_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [LEVEL:0]  c_cnt_last = (LEVEL+1)'(N - 1);
    localparam logic [WD_W-1:0] c_wd_last  = WD_W'(TIMEOUT - 1);
    // An odd number of ping-pong stages leaves the results in RAM1.
    localparam logic            c_out_sel  = ((LEVEL % 2) == 1);

    fft_ctrl_state_t  r_state;
    fft_ctrl_state_t  w_state_nxt;
    logic [LEVEL:0]   r_cnt;
    logic [LEVEL:0]   w_cnt_nxt;
    logic [WD_W-1:0]  r_wdog;
    logic [WD_W-1:0]  w_wdog_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic             r_frame_done;
    logic             w_frame_done_nxt;
    logic             r_timeout_err;
    logic             w_timeout_err_nxt;
    logic             r_rst_seen;
    logic             w_load_hs;
    logic             w_accept;
    logic             w_cnt_is_last;
    logic [LEVEL-1:0] w_load_idx;

    assign w_load_hs     = in_valid && (r_state == ST_LOAD);
    assign w_accept      = r_out_valid && out_ready;
    assign w_cnt_is_last = (r_cnt == c_cnt_last);

`ifdef FFT_CTRL_BITREV_EN
    bitrev #(
        .LEVEL  (LEVEL)
    ) u_bitrev (
        .i_data (r_cnt[LEVEL-1:0]),
        .o_data (w_load_idx)
    );
`else
    assign w_load_idx = r_cnt[LEVEL-1:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_wdog        <= '0;
            r_out_valid   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_rst_seen    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_wdog        <= w_wdog_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_frame_done  <= w_frame_done_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_rst_seen    <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_wdog_nxt        = '0;
        w_out_valid_nxt   = 1'b0;
        w_frame_done_nxt  = 1'b0;
        w_timeout_err_nxt = r_timeout_err;

        case (r_state)
            ST_IDLE: begin
                // r_rst_seen masks a start coinciding with reset release.
                if (start && r_rst_seen) begin
                    w_state_nxt       = ST_LOAD;
                    w_cnt_nxt         = '0;
                    w_timeout_err_nxt = 1'b0;
                end
            end
            ST_LOAD: begin
                if (w_load_hs) begin
                    if (w_cnt_is_last) begin
                        w_state_nxt = ST_ARM;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_ARM: begin
                w_state_nxt = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                w_wdog_nxt = r_wdog + 1'b1;
                if (fft_done) begin
                    w_state_nxt = ST_UNLOAD;
                    w_cnt_nxt   = '0;
                    w_wdog_nxt  = '0;
                end else if (r_wdog == c_wd_last) begin
                    w_state_nxt       = ST_IDLE;
                    w_wdog_nxt        = '0;
                    w_timeout_err_nxt = 1'b1;
                end
            end
            ST_UNLOAD: begin
                // The first UNLOAD cycle only issues the address; data follows.
                w_out_valid_nxt = 1'b1;
                if (w_accept) begin
                    if (w_cnt_is_last) begin
                        w_state_nxt      = ST_IDLE;
                        w_cnt_nxt        = '0;
                        w_out_valid_nxt  = 1'b0;
                        w_frame_done_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (abort) begin
            w_state_nxt       = ST_IDLE;
            w_cnt_nxt         = '0;
            w_wdog_nxt        = '0;
            w_out_valid_nxt   = 1'b0;
            w_frame_done_nxt  = 1'b0;
            w_timeout_err_nxt = r_timeout_err;
        end
    end

    assign in_ready    = (r_state == ST_LOAD);
    assign load_we     = in_valid && in_ready;
    assign fft_load    = (r_state == ST_LOAD);
    assign agu_reset   = (r_state == ST_COMPUTE);
    assign fft_enable  = (r_state == ST_COMPUTE);
    assign busy        = (r_state != ST_IDLE);
    assign load_addr   = (r_state == ST_LOAD)   ? w_load_idx       : '0;
    assign unload_addr = (r_state == ST_UNLOAD) ? r_cnt[LEVEL-1:0] : '0;
    assign out_sel     = c_out_sel;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_valid && w_cnt_is_last;
    assign frame_done  = r_frame_done;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fft_ctrl                                                                |
// | Self-checking bench for fft_ctrl: directed frames plus a cycle model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fft_ctrl;

    localparam int N       = 512;
    localparam int LEVEL   = 9;
    localparam int TIMEOUT = 2320;
`ifdef FFT_CTRL_BITREV_EN
    localparam int ADDR1   = 256;
`else
    localparam int ADDR1   = 1;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [LEVEL-1:0] load_addr;
    logic             load_we;
    logic             fft_load;
    logic             agu_reset;
    logic             fft_enable;
    logic             fft_done;
    logic [LEVEL-1:0] unload_addr;
    logic             out_sel;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             frame_done;
    logic             timeout_err;

    int checks = 0;
    int errors = 0;

    fft_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .load_addr   (load_addr),
        .load_we     (load_we),
        .fft_load    (fft_load),
        .agu_reset   (agu_reset),
        .fft_enable  (fft_enable),
        .fft_done    (fft_done),
        .unload_addr (unload_addr),
        .out_sel     (out_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int f_addr(input int idx);
        int r;
        r = idx;
`ifdef FFT_CTRL_BITREV_EN
        r = 0;
        for (int b = 0; b < LEVEL; b++) r |= ((idx >> b) & 1) << (LEVEL - 1 - b);
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle model: expected load address stream, unload index stream,
    // out_valid priming and frame_done pulse, derived from the handshakes.
    int m_load_idx = 0;
    int m_load_cnt = 0;
    int m_unl_idx  = 0;
    int m_unl_age  = 0;
    bit m_in_unl   = 0;
    bit m_fd_exp   = 0;

    always @(negedge clk) begin
        bit exp_ov;
        if (!reset) begin
            m_load_idx = 0;
            m_load_cnt = 0;
            m_unl_idx  = 0;
            m_unl_age  = 0;
            m_in_unl   = 0;
            m_fd_exp   = 0;
        end else begin
            exp_ov = m_in_unl && (m_unl_age > 0);
            chk("load_we_strobe", load_we, in_valid & in_ready);
            chk("out_sel", out_sel, 1);
            chk("out_valid", out_valid, exp_ov);
            chk("frame_done", frame_done, m_fd_exp);
            m_fd_exp = 0;
            if (load_we) begin
                chk("load_addr", load_addr, f_addr(m_load_idx));
                m_load_idx++;
                m_load_cnt++;
            end
            if (exp_ov) begin
                chk("unload_addr", unload_addr, m_unl_idx);
                chk("out_last", out_last, m_unl_idx == N - 1);
                if (out_ready) begin
                    if (m_unl_idx == N - 1) begin
                        m_fd_exp = 1;
                        m_in_unl = 0;
                    end
                    m_unl_idx++;
                end
            end else begin
                chk("out_last_idle", out_last, 0);
            end
            if (m_in_unl) m_unl_age++;
            if (fft_enable && fft_done && !abort) begin
                m_in_unl  = 1;
                m_unl_age = 0;
                m_unl_idx = 0;
            end
            if (!busy && start && !abort) begin
                m_load_idx = 0;
                m_load_cnt = 0;
            end
            if (abort) begin
                m_load_idx = 0;
                m_load_cnt = 0;
                m_unl_idx  = 0;
                m_in_unl   = 0;
                m_fd_exp   = 0;
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 1);
        chk("start_fft_load", fft_load, 1);
        chk("start_load_addr", load_addr, 0);
    endtask

    task automatic do_load(input bit gaps, input int abort_at);
        int n = 0;
        int guard = 0;
        bit stop = 0;
        while (!stop && n < N && guard < 3 * N) begin
            in_valid = !(gaps && (guard % 5 == 2));
            start    = gaps && (n == 10);
            if (n == abort_at) begin
                in_valid = 1'b0;
                start    = 1'b0;
                abort    = 1'b1;
                tick();
                abort = 1'b0;
                chk("abort_load_busy", busy, 0);
                chk("abort_load_out_valid", out_valid, 0);
                chk("abort_load_in_ready", in_ready, 0);
                stop = 1;
            end else begin
                if (n == 1) chk("load_addr_idx1", load_addr, ADDR1);
                if (in_valid && in_ready) n++;
                tick();
                guard++;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (abort_at < 0) begin
            chk("load_handshakes", n, N);
            chk("load_we_pulses", m_load_cnt, N);
        end
    endtask

    task automatic do_compute(input int done_at);
        int c = 0;
        chk("arm_agu_reset", agu_reset, 0);
        chk("arm_fft_enable", fft_enable, 0);
        chk("arm_busy", busy, 1);
        chk("arm_fft_load", fft_load, 0);
        tick();
        chk("cmp_agu_reset", agu_reset, 1);
        chk("cmp_fft_enable", fft_enable, 1);
        while (fft_enable && c < TIMEOUT + 8) begin
            c++;
            fft_done = (c == done_at);
            tick();
        end
        fft_done = 1'b0;
        if (done_at > 0) begin
            chk("compute_cycles", c, done_at);
        end else begin
            chk("timeout_cycles", c, TIMEOUT);
            chk("timeout_err_set", timeout_err, 1);
            chk("timeout_busy", busy, 0);
        end
    endtask

    task automatic do_unload(input int abort_at);
        logic [3:0] pat = 4'b1001;
        int acc = 0;
        int k = 0;
        int guard = 0;
        bit stop = 0;
        chk("unl_first_valid", out_valid, 0);
        chk("unl_first_addr", unload_addr, 0);
        chk("unl_fft_enable", fft_enable, 0);
        chk("unl_busy", busy, 1);
        while (!stop && acc < N && guard < 4 * N + 8) begin
            out_ready = pat[2'(k % 4)];
            k++;
            if (guard == 1) chk("unl_valid_after_1", out_valid, 1);
            if (out_valid && acc == abort_at) begin
                abort = 1'b1;
                tick();
                abort     = 1'b0;
                out_ready = 1'b0;
                chk("abort_unl_busy", busy, 0);
                chk("abort_unl_out_valid", out_valid, 0);
                stop = 1;
            end else begin
                if (out_valid && out_ready) begin
                    if (acc == N - 1) chk("out_last_final", out_last, 1);
                    acc++;
                end
                tick();
                guard++;
            end
        end
        out_ready = 1'b0;
        if (abort_at < 0) begin
            chk("unload_count", acc, N);
            chk("frame_done_pulse", frame_done, 1);
            chk("frame_end_busy", busy, 0);
            tick();
            chk("frame_done_drop", frame_done, 0);
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        fft_done  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_load_we", load_we, 0);
        chk("rst_fft_load", fft_load, 0);
        chk("rst_agu_reset", agu_reset, 0);
        chk("rst_fft_enable", fft_enable, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_load_addr", load_addr, 0);
        chk("rst_unload_addr", unload_addr, 0);

        // start coinciding with reset release is ignored
        @(negedge clk);
        #1;
        start = 1'b1;
        reset = 1'b1;
        tick();
        chk("start_at_release", busy, 0);
        start = 1'b0;

        // full frame, AGU modelled at LEVEL*N/2+1 cycles
        do_start();
        do_load(1'b0, -1);
        do_compute(2305);
        do_unload(-1);

        // input stalls and a stray start during LOAD
        do_start();
        do_load(1'b1, -1);
        do_compute(40);
        do_unload(-1);

        // watchdog expiry
        do_start();
        do_load(1'b0, -1);
        do_compute(0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        chk("start_abort_idle", busy, 0);
        chk("abort_keeps_timeout", timeout_err, 1);
        start = 1'b0;
        abort = 1'b0;
        do_start();
        chk("timeout_cleared", timeout_err, 0);

        // abort during LOAD at cnt=100
        do_load(1'b0, 100);
        do_start();
        do_load(1'b0, -1);
        do_compute(40);
        do_unload(37);
        do_start();
        do_load(1'b0, -1);
        do_compute(40);
        do_unload(-1);

        // asynchronous reset in the middle of COMPUTE
        do_start();
        do_load(1'b0, -1);
        tick();
        repeat (5) tick();
        chk("pre_rst_enable", fft_enable, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_enable", fft_enable, 0);
        chk("async_rst_agu", agu_reset, 0);
        chk("async_rst_in_ready", in_ready, 0);
        chk("async_rst_out_valid", out_valid, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        start = 1'b1;
        reset = 1'b1;
        tick();
        chk("start_at_release2", busy, 0);
        start = 1'b0;
        tick();
        chk("idle_after_release", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
